// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state enums and decode constants for the multiply/divide unit
package mdu_pkg;
    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } md_op_e;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} mdu_state_e;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
endpackage

// File: rtl/mdu_iter_datapath.sv
// mdu_iter_datapath: shared radix-2 shift-add multiply / restoring divide on magnitudes
// Ports: clk, rst_n (async active-low); load latches a/b/div and clears the accumulator;
//        step runs one iteration; hi/lo are product high/low or remainder/quotient.
// Config: MDU_FAST_MUL_EN loads the full product in one cycle on a multiply load.
module mdu_iter_datapath #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            div,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    logic [XLEN-1:0] b_q;
    logic            div_q;
    logic [XLEN:0]   mul_sum, shl, diff;

    // diff[XLEN] set means the trial subtraction went negative (restore)
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
        shl     = {hi, lo[XLEN-1]};
        diff    = shl - {1'b0, b_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi    <= '0;
            lo    <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            b_q   <= b;
            div_q <= div;
`ifdef MDU_FAST_MUL_EN
            {hi, lo} <= div ? {{XLEN{1'b0}}, a} : {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
`else
            hi <= '0;
            lo <= a;
`endif
        end else if (step) begin
            if (div_q) begin
                hi <= diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
                lo <= {lo[XLEN-2:0], ~diff[XLEN]};
            end else begin
                hi <= mul_sum[XLEN:1];
                lo <= {mul_sum[0], lo[XLEN-1:1]};
            end
        end
    end
endmodule

// File: rtl/mdu_controller.sv
// mdu_controller: RV M-extension decode, IDLE/CALC/DONE sequencing and sign fix-up
// Ports: clk, rst_n (async active-low); ALUOp/Funct7/Funct3 decode fields; valid_in, rs1, rs2
//        operands; flush aborts. Outputs: is_md (comb match), stall, ready (IDLE),
//        result and one-cycle result_valid.
// Config: MDU_FAST_MUL_EN sends multiplies straight to DONE (single-cycle multiplier).
module mdu_controller
    import mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            valid_in,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            is_md,
    output logic            stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            ready
);
    mdu_state_e        state;
    logic [CNT_W-1:0]  count;
    md_op_e            op_in, op_q;
    logic              accept, in_div, a_sgn, b_sgn, a_neg, b_neg, in_dz, in_ovf, skip;
    logic              a_neg_q, b_neg_q, dz_q, ovf_q;
    logic [XLEN-1:0]   a_mag, b_mag, rs1_q, hi, lo, q_fix, r_fix, res;
    logic [2*XLEN-1:0] prod_fix;

    assign is_md  = (ALUOp == ALUOP_RTYPE) && (Funct7 == FUNCT7_MULDIV);
    assign ready  = (state == S_IDLE);
    assign accept = valid_in & is_md & ready & ~flush;
    assign stall  = accept | (state != S_IDLE);
    assign op_in  = md_op_e'(Funct3);
    assign in_div = Funct3[2];
    assign a_sgn  = op_in inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    assign b_sgn  = op_in inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    assign a_neg  = a_sgn & rs1[XLEN-1];
    assign b_neg  = b_sgn & rs2[XLEN-1];
    assign a_mag  = a_neg ? -rs1 : rs1;
    assign b_mag  = b_neg ? -rs2 : rs2;
    assign in_dz  = in_div & (rs2 == '0);
    assign in_ovf = in_div & a_sgn & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);
`ifdef MDU_FAST_MUL_EN
    assign skip   = in_dz | in_ovf | ~in_div;
`else
    assign skip   = in_dz | in_ovf;
`endif

    mdu_iter_datapath #(.XLEN(XLEN)) u_dp (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .step  (state == S_CALC),
        .div   (in_div),
        .a     (a_mag),
        .b     (b_mag),
        .hi    (hi),
        .lo    (lo)
    );

    // quotient sign is a^b, remainder follows the dividend
    always_comb begin
        prod_fix = (a_neg_q ^ b_neg_q) ? -{hi, lo} : {hi, lo};
        q_fix    = (a_neg_q ^ b_neg_q) ? -lo : lo;
        r_fix    = a_neg_q ? -hi : hi;
        res      = dz_q    ? (op_q[1] ? rs1_q : '1) :
                   ovf_q   ? (op_q[1] ? '0 : rs1_q) :
                   op_q[2] ? (op_q[1] ? r_fix : q_fix) :
                   (op_q == MD_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            count        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            op_q         <= MD_MUL;
            a_neg_q      <= 1'b0;
            b_neg_q      <= 1'b0;
            dz_q         <= 1'b0;
            ovf_q        <= 1'b0;
            rs1_q        <= '0;
        end else begin
            result_valid <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (accept) begin
                        op_q    <= op_in;
                        a_neg_q <= a_neg;
                        b_neg_q <= b_neg;
                        dz_q    <= in_dz;
                        ovf_q   <= in_ovf;
                        rs1_q   <= rs1;
                        count   <= '0;
                        state   <= skip ? S_DONE : S_CALC;
                    end
                    S_CALC: begin
                        count <= count + CNT_W'(1);
                        if (count == CNT_W'(XLEN - 1)) state <= S_DONE;
                    end
                    S_DONE: begin
                        result       <= res;
                        result_valid <= 1'b1;
                        state        <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdu_controller.sv
// tb_mdu_controller: scoreboard bench for mdu_controller (XLEN=32)
module tb_mdu_controller;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    logic        clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0, flush = 1'b0;
    logic [1:0]  ALUOp = '0;
    logic [6:0]  Funct7 = '0;
    logic [2:0]  Funct3 = '0;
    logic [31:0] rs1 = '0, rs2 = '0, result;
    logic        is_md, stall, result_valid, ready;
    int          checks = 0, errors = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    mdu_controller #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .valid_in(valid_in), .rs1(rs1), .rs2(rs2), .flush(flush), .is_md(is_md),
        .stall(stall), .result(result), .result_valid(result_valid), .ready(ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub, p;
        logic signed [31:0] sq;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        p   = 64'(sa * sb);
        if (f3 == 3'd2) p = 64'(sa * longint'(ub));
        if (f3 == 3'd3) p = ua * ub;
        case (f3)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (ovf) return a;
                sq = $signed(a) / $signed(b);
                return sq;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                sq = $signed(a) % $signed(b);
                return sq;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // drives one M op, optionally pokes a spurious valid_in while busy, waits for result_valid
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int poke, output logic [31:0] res, output int lat,
                          output int st_cnt, output logic st_acc, output logic st_rv);
        @(negedge clk);
        ALUOp = 2'b10; Funct7 = 7'b1; Funct3 = f3; rs1 = a; rs2 = b; valid_in = 1'b1;
        #1 st_acc = stall;
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        lat = 1;
        st_cnt = 0;
        while (!result_valid && lat < 200) begin
            if (stall) st_cnt++;
            @(negedge clk);
            lat++;
            valid_in = (lat == poke);
            if (lat == poke) begin
                Funct3 = 3'd4; rs1 = $urandom; rs2 = $urandom;
            end
        end
        valid_in = 1'b0;
        res = result;
        st_rv = stall;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got=%b exp=0", result_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul;
        logic [31:0] r, e;
        int l, sc, el;
        logic sa, sr;
        logic [2:0] f3s[2];
        logic [31:0] exps[2];
        f3s = '{3'd3, 3'd1};
        exps = '{32'hFFFFFFFE, 32'h0};
        exp_q.push_back(32'hFFFFFFEB); lat_q.push_back(MUL_LAT);
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 0, r, l, sc, sa, sr);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (r !== e) begin errors++; $display("FAIL mul_7x-3 got=%h exp=%h", r, e); end
        checks++; if (l != el) begin errors++; $display("FAIL mul_latency got=%0d exp=%0d", l, el); end
        checks++; if (sa !== 1'b1) begin errors++; $display("FAIL mul_stall_accept got=%b exp=1", sa); end
        checks++; if (sc != el - 1) begin errors++; $display("FAIL mul_stall_cycles got=%0d exp=%0d", sc, el - 1); end
        checks++; if (sr !== 1'b0) begin errors++; $display("FAIL mul_stall_at_rv got=%b exp=0", sr); end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(exps[i]); lat_q.push_back(MUL_LAT);
            run_op(f3s[i], 32'hFFFFFFFF, 32'hFFFFFFFF, 0, r, l, sc, sa, sr);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            checks++; if (r !== e) begin errors++; $display("FAIL mulh_f3=%0d got=%h exp=%h", f3s[i], r, e); end
            checks++; if (l != el) begin errors++; $display("FAIL mulh_lat_f3=%0d got=%0d exp=%0d", f3s[i], l, el); end
        end
    endtask

    task automatic test_div;
        logic [31:0] r, e;
        int l, sc, el;
        logic sa, sr;
        logic [2:0]  f3s[8];
        logic [31:0] as[8], bs[8], exps[8];
        int          lats[8];
        f3s  = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        as   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd9, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9};
        bs   = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        exps = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9};
        lats = '{34, 34, 2, 2, 2, 2, 2, 2};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(exps[i]); lat_q.push_back(lats[i]);
            run_op(f3s[i], as[i], bs[i], 0, r, l, sc, sa, sr);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            checks++; if (r !== e) begin errors++; $display("FAIL div_case%0d got=%h exp=%h", i, r, e); end
            checks++; if (l != el) begin errors++; $display("FAIL div_lat_case%0d got=%0d exp=%0d", i, l, el); end
            checks++; if (sc != el - 1) begin errors++; $display("FAIL div_stall_case%0d got=%0d exp=%0d", i, sc, el - 1); end
        end
    endtask

    task automatic test_random;
        logic [31:0] r, e, a, b;
        logic [2:0] f3;
        int l, sc, el;
        logic sa, sr;
        for (int i = 0; i < 24; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 6 == 5) ? 32'h0 : (i % 4 == 3) ? 32'($urandom_range(1, 15)) : $urandom;
            exp_q.push_back(model(f3, a, b));
            lat_q.push_back(!f3[2] ? MUL_LAT : (b == 0 || (f3 inside {3'd4, 3'd6} && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 2 : 34);
            run_op(f3, a, b, 0, r, l, sc, sa, sr);
            e = exp_q.pop_front(); el = lat_q.pop_front();
            checks++; if (r !== e) begin errors++; $display("FAIL rand%0d f3=%0d a=%h b=%h got=%h exp=%h", i, f3, a, b, r, e); end
            checks++; if (l != el) begin errors++; $display("FAIL rand_lat%0d got=%0d exp=%0d", i, l, el); end
        end
    endtask

    task automatic test_flush;
        logic [31:0] r, e;
        int l, sc, el, rvs;
        logic sa, sr;
        @(negedge clk);
        ALUOp = 2'b10; Funct7 = 7'b1; Funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd7; valid_in = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            valid_in = 1'b0;
        end
        flush = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL flush_busy_ready got=%b exp=0", ready); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", ready); end
        rvs = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) rvs++;
        end
        checks++; if (rvs != 0) begin errors++; $display("FAIL flush_no_rv got=%0d exp=0", rvs); end
        exp_q.push_back(32'd12); lat_q.push_back(MUL_LAT);
        run_op(3'd0, 32'd3, 32'd4, 0, r, l, sc, sa, sr);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (r !== e) begin errors++; $display("FAIL flush_then_mul got=%h exp=%h", r, e); end
        checks++; if (l != el) begin errors++; $display("FAIL flush_then_mul_lat got=%0d exp=%0d", l, el); end
        @(negedge clk);
        Funct3 = 3'd0; valid_in = 1'b1; flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_prio_stall got=%b exp=0", stall); end
        @(negedge clk);
        valid_in = 1'b0; flush = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flush_prio_ready got=%b exp=1", ready); end
    endtask

    task automatic test_non_md;
        int st;
        @(negedge clk);
        ALUOp = 2'b10; Funct7 = 7'b0; Funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd6; valid_in = 1'b1;
        #1;
        checks++; if (is_md !== 1'b0) begin errors++; $display("FAIL nonmd_is_md got=%b exp=0", is_md); end
        st = 0;
        repeat (4) begin
            @(negedge clk);
            if (stall || !ready) st++;
        end
        checks++; if (st != 0) begin errors++; $display("FAIL nonmd_stall got=%0d exp=0", st); end
        Funct7 = 7'b1;
        #1;
        checks++; if (is_md !== 1'b1) begin errors++; $display("FAIL md_is_md got=%b exp=1", is_md); end
        ALUOp = 2'b00;
        valid_in = 1'b0;
        #1;
        checks++; if (is_md !== 1'b0) begin errors++; $display("FAIL aluop_is_md got=%b exp=0", is_md); end
    endtask

    task automatic test_reset_mid;
        int rvs;
        @(negedge clk);
        ALUOp = 2'b10; Funct7 = 7'b1; Funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got=%b exp=0", stall); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rstmid_result got=%h exp=0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        rvs = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) rvs++;
        end
        checks++; if (rvs != 0) begin errors++; $display("FAIL rstmid_no_rv got=%0d exp=0", rvs); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r, e;
        int l, sc, el;
        logic sa, sr;
        exp_q.push_back(32'd42); lat_q.push_back(MUL_LAT);
        run_op(3'd0, 32'd6, 32'd7, (MUL_LAT > 6) ? 5 : 0, r, l, sc, sa, sr);
        e = exp_q.pop_front(); el = lat_q.pop_front();
        checks++; if (r !== e) begin errors++; $display("FAIL busy_poke got=%h exp=%h", r, e); end
        checks++; if (l != el) begin errors++; $display("FAIL busy_poke_lat got=%0d exp=%0d", l, el); end
        repeat (3) @(negedge clk);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rv_strobe got=%b exp=0", result_valid); end
        checks++; if (result !== e) begin errors++; $display("FAIL result_hold got=%h exp=%h", result, e); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_random();
        test_flush();
        test_non_md();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
